// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU datapath blocks.
// sat_add works on sign-extended operands so one function serves every element width.
package tpu_pkg;

  typedef enum logic [0:0] {
    ACC_FILL,
    ACC_DRAIN
  } acc_state_t;

  // Widest element sat_add can handle is SatW-1 bits, leaving headroom for the carry.
  localparam int unsigned SatW = 64;

  typedef struct packed {
    logic [SatW-1:0] sum;
    logic            ovf;
  } sat_add_t;

  // Operands must already be sign-extended from `width` bits to SatW bits.
  function automatic sat_add_t sat_add(input logic signed [SatW-1:0] a,
                                       input logic signed [SatW-1:0] b,
                                       input int unsigned            width);
    logic signed [SatW-1:0] full;
    logic signed [SatW-1:0] max_v;
    logic signed [SatW-1:0] min_v;
    sat_add_t               res;
    full  = a + b;
    max_v = $signed((SatW'(1) << (width - 1)) - SatW'(1));
    min_v = ~max_v;
    res.sum = full;
    res.ovf = 1'b0;
    if (full > max_v) begin
      res.sum = max_v;
      res.ovf = 1'b1;
    end else if (full < min_v) begin
      res.sum = min_v;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational signed adder that either clamps to the element range or wraps.
// ovf_o flags a clamp, so it is always low in wrapping mode.
module sat_adder
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  ovf_o
);

  localparam int unsigned ExtW = SatW - DATA_WIDTH;

  sat_add_t              res;
  logic [DATA_WIDTH-1:0] wrap_sum;
  logic                  unused_sum_hi;

  assign res = sat_add({{ExtW{a_i[DATA_WIDTH-1]}}, a_i},
                       {{ExtW{b_i[DATA_WIDTH-1]}}, b_i},
                       DATA_WIDTH);

  assign wrap_sum      = a_i + b_i;
  // Clamped results always fit in DATA_WIDTH, so the upper bits carry no information.
  assign unused_sum_hi = ^res.sum[SatW-1:DATA_WIDTH];

  assign sum_o = SATURATE ? res.sum[DATA_WIDTH-1:0] : wrap_sum;
  assign ovf_o = SATURATE & res.ovf;

endmodule

// File: rtl/accumulator_vec.sv
// Collects a DEPTH-element partial-sum vector (overwrite or accumulate), then drains it
// downstream with valid/ready. Fill and drain never overlap.
module accumulator_vec
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_accum_i,
  input  logic                  in_flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  sat_o
);

  localparam int unsigned      IDX_W   = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  acc_state_t            state_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      wr_idx_q;
  logic [IDX_W-1:0]      rd_idx_q;
  logic                  mode_acc_q;
  logic                  mode_flush_q;
  logic                  sat_q;

  logic                  in_fire;
  logic                  out_fire;
  logic                  first_beat;
  logic                  last_beat;
  logic                  acc_eff;
  logic                  flush_eff;
  logic                  sat_set;
  logic                  sat_clr;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_ovf;
  logic [DATA_WIDTH-1:0] wr_data;

  assign in_ready_o  = (state_q == ACC_FILL);
  assign out_valid_o = (state_q == ACC_DRAIN);
  assign out_data_o  = mem_q[rd_idx_q];
  assign out_last_o  = out_valid_o && (rd_idx_q == LastIdx);
  assign sat_o       = sat_q;

  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = out_valid_o & out_ready_i;
  assign first_beat = (wr_idx_q == '0);
  assign last_beat  = (wr_idx_q == LastIdx);

  // Beat 0 acts on the live mode bits; later beats use the copies captured on beat 0.
  assign acc_eff   = first_beat ? in_accum_i : mode_acc_q;
  assign flush_eff = first_beat ? in_flush_i : mode_flush_q;

  sat_adder #(
    .DATA_WIDTH(DATA_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat_adder (
    .a_i  (mem_q[wr_idx_q]),
    .b_i  (in_data_i),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  assign wr_data = acc_eff ? add_sum : in_data_i;
  assign sat_set = in_fire & acc_eff & add_ovf;
  assign sat_clr = in_fire & first_beat & ~in_accum_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (in_fire) begin
      mem_q[wr_idx_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACC_FILL;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      mode_acc_q   <= 1'b0;
      mode_flush_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      unique case (state_q)
        ACC_FILL: begin
          if (in_fire) begin
            if (first_beat) begin
              mode_acc_q   <= in_accum_i;
              mode_flush_q <= in_flush_i;
            end
            if (last_beat) begin
              wr_idx_q <= '0;
              if (flush_eff) begin
                state_q <= ACC_DRAIN;
              end
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
            end
          end
        end
        ACC_DRAIN: begin
          if (out_fire) begin
            if (rd_idx_q == LastIdx) begin
              rd_idx_q <= '0;
              state_q  <= ACC_FILL;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= ACC_FILL;
      endcase
      // A clamp in the same cycle wins over the overwrite clear.
      if (sat_set) begin
        sat_q <= 1'b1;
      end else if (sat_clr) begin
        sat_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accumulator_vec.sv
// Directed bench: a saturating and a wrapping accumulator_vec share one stimulus stream.
module tb_accumulator_vec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_accum;
  logic        in_flush;
  logic        out_ready;

  logic        in_ready,   w_in_ready;
  logic        out_valid,  w_out_valid;
  logic [15:0] out_data,   w_out_data;
  logic        out_last,   w_out_last;
  logic        sat,        w_sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vld;
    logic [15:0] din;
    logic        acc;
    logic        flush;
    logic        ordy;
    logic        e_irdy;
    logic        e_ovld;
    logic [15:0] e_data;
    logic        e_last;
    logic        e_sat;
    logic [15:0] e_wdata;
    logic        e_wsat;
  } vec_t;

  vec_t p1[$];
  vec_t p2[$];

  accumulator_vec #(.DATA_WIDTH(16), .DEPTH(4), .SATURATE(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_accum_i (in_accum),
    .in_flush_i (in_flush),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .sat_o      (sat)
  );

  accumulator_vec #(.DATA_WIDTH(16), .DEPTH(4), .SATURATE(1'b0)) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (w_in_ready),
    .in_data_i  (in_data),
    .in_accum_i (in_accum),
    .in_flush_i (in_flush),
    .out_valid_o(w_out_valid),
    .out_ready_i(out_ready),
    .out_data_o (w_out_data),
    .out_last_o (w_out_last),
    .sat_o      (w_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t beat(input logic [15:0] d, input logic a, input logic f,
                                input logic s, input logic ws);
    vec_t v;
    v.vld = 1'b1; v.din = d; v.acc = a; v.flush = f; v.ordy = 1'b1;
    v.e_irdy = 1'b1; v.e_ovld = 1'b0; v.e_data = '0; v.e_last = 1'b0;
    v.e_sat = s; v.e_wdata = '0; v.e_wsat = ws;
    return v;
  endfunction

  // nv drives a noise beat that must be ignored while draining.
  function automatic vec_t drn(input logic [15:0] ed, input logic [15:0] ewd, input logic l,
                               input logic r, input logic nv, input logic s);
    vec_t v;
    v.vld = nv; v.din = 16'h7777; v.acc = 1'b0; v.flush = 1'b1; v.ordy = r;
    v.e_irdy = 1'b0; v.e_ovld = 1'b1; v.e_data = ed; v.e_last = l;
    v.e_sat = s; v.e_wdata = ewd; v.e_wsat = 1'b0;
    return v;
  endfunction

  function automatic vec_t idle(input logic s);
    vec_t v;
    v = beat(16'h0, 1'b0, 1'b0, s, 1'b0);
    v.vld = 1'b0;
    return v;
  endfunction

  // Called at a falling edge: drive inputs, check state-driven outputs, advance one cycle.
  task automatic run_table(input vec_t q[$], input string tag);
    foreach (q[i]) begin
      in_valid  = q[i].vld;
      in_data   = q[i].din;
      in_accum  = q[i].acc;
      in_flush  = q[i].flush;
      out_ready = q[i].ordy;
      #1;
      check({tag, " in_ready"},  i, 32'(in_ready),  32'(q[i].e_irdy));
      check({tag, " out_valid"}, i, 32'(out_valid), 32'(q[i].e_ovld));
      check({tag, " out_last"},  i, 32'(out_last),  32'(q[i].e_last));
      check({tag, " sat"},       i, 32'(sat),       32'(q[i].e_sat));
      check({tag, " w_valid"},   i, 32'(w_out_valid), 32'(q[i].e_ovld));
      check({tag, " w_sat"},     i, 32'(w_sat),     32'(q[i].e_wsat));
      if (q[i].e_ovld) begin
        check({tag, " out_data"}, i, 32'(out_data),   32'(q[i].e_data));
        check({tag, " w_data"},   i, 32'(w_out_data), 32'(q[i].e_wdata));
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " in_ready"},  0, 32'(in_ready),   32'd1);
    check({tag, " out_valid"}, 0, 32'(out_valid),  32'd0);
    check({tag, " out_data"},  0, 32'(out_data),   32'd0);
    check({tag, " out_last"},  0, 32'(out_last),   32'd0);
    check({tag, " sat"},       0, 32'(sat),        32'd0);
    check({tag, " w_data"},    0, 32'(w_out_data), 32'd0);
    check({tag, " w_valid"},   0, 32'(w_out_valid), 32'd0);
  endtask

  initial begin
    // Overwrite+flush 1..4; later beats carry misleading mode bits that must be ignored.
    p1.push_back(beat(16'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(beat(16'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    p1.push_back(drn(16'd1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'd2, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'd3, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'd4, 16'd4, 1'b1, 1'b1, 1'b0, 1'b0));
    // Overwrite without flush, then accumulate+flush 10..40.
    p1.push_back(beat(16'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    p1.push_back(beat(16'd3, 1'b1, 1'b1, 1'b0, 1'b0));
    p1.push_back(beat(16'd4, 1'b1, 1'b1, 1'b0, 1'b0));
    p1.push_back(beat(16'd10, 1'b1, 1'b1, 1'b0, 1'b0));
    p1.push_back(beat(16'd20, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'd30, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'd40, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(drn(16'd11, 16'd11, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'd22, 16'd22, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'd33, 16'd33, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'd44, 16'd44, 1'b1, 1'b1, 1'b0, 1'b0));
    // Back-to-back overwrite+flush, then 3-cycle stall at element 2 with noise beats.
    p1.push_back(beat(16'h0100, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(beat(16'h0200, 1'b1, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'h0300, 1'b1, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'h0400, 1'b1, 1'b0, 1'b0, 1'b0));
    p1.push_back(drn(16'h0100, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'h0200, 16'h0200, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'h0300, 16'h0300, 1'b0, 1'b0, 1'b1, 1'b0));
    p1.push_back(drn(16'h0300, 16'h0300, 1'b0, 1'b0, 1'b1, 1'b0));
    p1.push_back(drn(16'h0300, 16'h0300, 1'b0, 1'b0, 1'b1, 1'b0));
    p1.push_back(drn(16'h0300, 16'h0300, 1'b0, 1'b1, 1'b1, 1'b0));
    p1.push_back(drn(16'h0400, 16'h0400, 1'b1, 1'b1, 1'b0, 1'b0));
    // Back-to-back accumulate proves the stall-time noise never reached mem.
    p1.push_back(beat(16'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    p1.push_back(beat(16'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(drn(16'h0101, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'h0201, 16'h0201, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'h0301, 16'h0301, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'h0401, 16'h0401, 1'b1, 1'b1, 1'b0, 1'b0));
    // Saturation: positive and negative clamps, wrapping twin for comparison.
    p1.push_back(beat(16'h7F00, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'h8100, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'h0200, 1'b1, 1'b1, 1'b0, 1'b0));
    p1.push_back(beat(16'h8100, 1'b0, 1'b0, 1'b1, 1'b0));
    p1.push_back(beat(16'h0001, 1'b0, 1'b0, 1'b1, 1'b0));
    p1.push_back(beat(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0));
    p1.push_back(drn(16'h7FFF, 16'h8100, 1'b0, 1'b1, 1'b0, 1'b1));
    p1.push_back(drn(16'h8000, 16'h0200, 1'b0, 1'b1, 1'b0, 1'b1));
    p1.push_back(drn(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1));
    p1.push_back(drn(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1));
    // Sticky across an accumulate vector; cleared only by the next overwrite beat 0.
    for (int i = 0; i < 4; i++) p1.push_back(beat(16'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    p1.push_back(beat(16'd5, 1'b0, 1'b1, 1'b1, 1'b0));
    p1.push_back(beat(16'd6, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(beat(16'd8, 1'b0, 1'b0, 1'b0, 1'b0));
    p1.push_back(drn(16'd5, 16'd5, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'd6, 16'd6, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'd7, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0));
    p1.push_back(drn(16'd8, 16'd8, 1'b1, 1'b1, 1'b0, 1'b0));

    // After the mid-fill reset: accumulate onto cleared mem.
    p2.push_back(beat(16'd5, 1'b1, 1'b1, 1'b0, 1'b0));
    p2.push_back(beat(16'd6, 1'b0, 1'b0, 1'b0, 1'b0));
    p2.push_back(beat(16'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    p2.push_back(beat(16'd8, 1'b0, 1'b0, 1'b0, 1'b0));
    p2.push_back(drn(16'd5, 16'd5, 1'b0, 1'b1, 1'b0, 1'b0));
    p2.push_back(drn(16'd6, 16'd6, 1'b0, 1'b1, 1'b0, 1'b0));
    p2.push_back(drn(16'd7, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0));
    p2.push_back(drn(16'd8, 16'd8, 1'b1, 1'b1, 1'b0, 1'b0));
    p2.push_back(idle(1'b0));

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_accum  = 1'b0;
    in_flush  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_table(p1, "p1");

    // Two accepted beats, the first saturating, then an async reset between edges.
    in_valid = 1'b1; in_data = 16'h7FFF; in_accum = 1'b1; in_flush = 1'b1;
    @(negedge clk);
    in_data = 16'h0001; in_accum = 1'b0; in_flush = 1'b0;
    @(posedge clk);
    #1;
    check("pre-rst sat",      0, 32'(sat),        32'd1);
    check("pre-rst out_data", 0, 32'(out_data),   32'h7FFF);
    check("pre-rst w_data",   0, 32'(w_out_data), 32'h8004);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_values("async-rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_table(p2, "p2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulator_vec.md
# accumulator_vec

Parametrised successor to the 4-entry accumulator. It collects a DEPTH-element vector of partial sums from one systolic-array column stream, either overwriting or saturating-adding into its register buffer, then drains the vector downstream with a valid/ready handshake. It sits between the systolic array outputs and the activation/unified-buffer write path, and enables K-dimension tiling by summing partial products across successive tiles.

## Interface

Parameters:
- DATA_WIDTH, 16: element width, signed two's complement (Q8.8 in the current datapath).
- DEPTH, 4: elements per vector; must be ≥ 2. IDX_W = $clog2(DEPTH).
- SATURATE, 1: 1 = saturating add; 0 = wrapping add.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when high with in_valid_i.
- in_data_i  in  DATA_WIDTH  partial-sum element.
- in_accum_i  in  1  sampled on beat 0 only: 1 = add to stored value, 0 = overwrite.
- in_flush_i  in  1  sampled on beat 0 only: 1 = drain the vector once it is complete.
- out_valid_o  out  1  output element valid.
- out_ready_i  in  1  downstream accepts element.
- out_data_o  out  DATA_WIDTH  output element, equal to mem[rd_idx].
- out_last_o  out  1  high with out_valid_o on element DEPTH-1.
- sat_o  out  1  sticky saturation flag.

## Operation

- Storage: mem[0..DEPTH-1], DATA_WIDTH each. wr_idx and rd_idx are IDX_W-bit counters. mode_acc_q and mode_flush_q are captured on beat 0.
- States: FILL and DRAIN.
- FILL: in_ready_o = 1. On an accepted beat:
  - At wr_idx == 0, the beat uses in_accum_i and in_flush_i directly and also registers them. Later beats use the registered values.
  - Overwrite: mem[wr_idx] ← in_data_i. Accumulate: mem[wr_idx] ← add(mem[wr_idx], in_data_i).
  - wr_idx increments. At wr_idx == DEPTH-1 it wraps to 0, and the block goes to DRAIN if flush is set, otherwise stays in FILL.
- DRAIN: in_ready_o = 0 and out_valid_o = 1.
  - rd_idx advances on each out_valid_o & out_ready_i.
  - On the handshake at rd_idx == DEPTH-1: rd_idx ← 0 and the block returns to FILL.
  - mem is retained after a drain. It is overwritten only by a later overwrite vector.
- Add rule: full-width signed add.
  - SATURATE = 1: positive overflow clamps to 0x7FFF (generically 2^(DATA_WIDTH-1)-1). Negative overflow clamps to 0x8000 (generically -2^(DATA_WIDTH-1)). Either case sets sat_o.
  - SATURATE = 0: the result wraps and sat_o stays 0.
- sat_o is cleared by reset and by beat 0 of an overwrite vector. In the same cycle, a set takes priority over a clear.
- Reset (async, any state): state = FILL, wr_idx = rd_idx = 0, mem = 0, mode registers = 0, sat_o = 0.

## Timing

- Reset values: in_ready_o = 1, out_valid_o = 0, out_data_o = 0, out_last_o = 0, sat_o = 0.
- Latency: if the last input beat is accepted at edge N, out_valid_o is high from cycle N+1, and out_data_o = mem[0] already holds the updated value. Drain takes DEPTH cycles at full throughput.
- A new vector is accepted no earlier than the cycle after the final drain handshake. There is no overlap of fill and drain.
- Backpressure: while out_valid_o is high and out_ready_i is low, out_data_o, out_last_o and rd_idx stay stable.
- in_valid_i during DRAIN is ignored, because in_ready_o = 0.
- in_accum_i and in_flush_i on beats 1..DEPTH-1 are don't-care.
- Reset mid-fill or mid-drain: the partial vector is discarded, and the next accepted beat is beat 0.

## Structure

- Shared package tpu_pkg holds:
  - enum acc_state_t {ACC_FILL, ACC_DRAIN};
  - a function sat_add(a, b, width) returning the sum and an overflow flag.
- Sub-module sat_adder: combinational, parametrised by DATA_WIDTH and SATURATE. Outputs are sum and ovf.
- Top level: the FSM, the mem array, counters, and the output mux.

## Test plan

- Overwrite + flush, DEPTH = 4, inputs 1,2,3,4 → outputs 1,2,3,4, with out_last_o on the 4th; in_ready_o = 0 for exactly 4 cycles at full ready.
- Overwrite no-flush 1,2,3,4, then accumulate + flush 10,20,30,40 → no output after the first vector; second vector outputs 11,22,33,44.
- Saturation, SATURATE = 1:
  - mem 0x7F00 + 0x0200 → 0x7FFF, sat_o = 1.
  - 0x8100 + 0x8100 → 0x8000.
  - sat_o stays 1 until the next overwrite vector.
  - With SATURATE = 0, the first case gives 0x8100 and sat_o = 0.
- Backpressure: hold out_ready_i low for 3 cycles at element 2 → out_data_o is held at element 2 and in_valid_i is ignored; the full sequence completes unchanged.
- Async reset: assert rst_n low between edges after 2 accepted beats → outputs are at reset values immediately, without waiting for a clock edge. A following accumulate + flush vector 5,6,7,8 outputs 5,6,7,8 because mem was cleared.
- Back-to-back: an overwrite + flush vector presented on the cycle after the final drain handshake is accepted with no bubble, and its output is correct.
